// File: rtl/mc_control_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, FSM state
// encoding, instruction classes and the pc/write-back/branch encodings.
package mc_control_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI
  } iclass_t;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  // beq/bne compare through the zero flag (111); the rest select an ALU compare.
  function automatic logic [2:0] branch_type(input logic [2:0] funct3);
    case (funct3)
      3'b000, 3'b001: branch_type = 3'b111;
      3'b100:         branch_type = 3'b000;
      3'b101:         branch_type = 3'b001;
      3'b110:         branch_type = 3'b100;
      3'b111:         branch_type = 3'b101;
      default:        branch_type = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_if.sv
// Instruction- and data-memory handshake bundle between controller and memories.
interface mc_control_if;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;

  modport master (
    output imem_req, input imem_ack, input imem_rdata,
    output dmem_req, output dmem_we, input dmem_ack
  );

  modport slave (
    input imem_req, output imem_ack, output imem_rdata,
    input dmem_req, input dmem_we, output dmem_ack
  );
endinterface

// File: rtl/mc_control_ctrl_decode.sv
// Combinational opcode classifier; unknown opcodes are flagged as not legal.
module ctrl_decode
  import mc_control_pkg::*;
(
  input  logic [6:0] opcode,
  output iclass_t    iclass,
  output logic       legal
);

  always_comb begin
    iclass = C_R;
    legal  = 1'b1;
    case (opcode)
      OP_R:      iclass = C_R;
      OP_I:      iclass = C_I;
      OP_LOAD:   iclass = C_LOAD;
      OP_STORE:  iclass = C_STORE;
      OP_BRANCH: iclass = C_BRANCH;
      OP_JAL:    iclass = C_JAL;
      OP_JALR:   iclass = C_JALR;
      OP_LUI:    iclass = C_LUI;
      default:   legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle CPU control FSM: fetch/decode/execute/memory/write-back sequencing
// with a sticky trap on illegal opcodes.
module mc_control
  import mc_control_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  mc_control_if.master      mem,
  output logic [31:0]       instr_q,
  output logic [1:0]        ALUOp,
  output logic              ALUSrc,
  output logic [2:0]        BranchType,
  output logic              Jump,
  output logic              lui,
  input  logic              zero,
  input  logic              less,
  output logic              pc_write,
  output logic [1:0]        pc_src,
  output logic              reg_write,
  output logic [1:0]        wb_sel,
  output logic              illegal,
  output logic [2:0]        state_o
);

  state_t      state_reg;
  logic [31:0] instr_reg;
  logic        illegal_reg;
  iclass_t     iclass;
  logic        legal;
  logic        taken;

  ctrl_decode u_decode (
    .opcode (instr_reg[6:0]),
    .iclass (iclass),
    .legal  (legal)
  );

  assign instr_q = instr_reg;
  assign illegal = illegal_reg;
  assign state_o = state_reg;

  always_comb begin
    case (instr_reg[14:12])
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      default: taken = less;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      instr_reg   <= '0;
      illegal_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE:  state_reg <= S_FETCH;
        S_FETCH: begin
          if (mem.imem_ack) begin
            instr_reg <= mem.imem_rdata;
            state_reg <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (legal) begin
            state_reg <= S_EXEC;
          end else begin
            state_reg   <= S_TRAP;
            illegal_reg <= 1'b1;
          end
        end
        S_EXEC: begin
          case (iclass)
            C_BRANCH:        state_reg <= S_FETCH;
            C_LOAD, C_STORE: state_reg <= S_MEM;
            default:         state_reg <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem.dmem_ack) state_reg <= (iclass == C_STORE) ? S_FETCH : S_WB;
        end
        S_WB:    state_reg <= S_FETCH;
        S_TRAP:  state_reg <= S_TRAP;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Outputs follow the current state and latched instruction; only the
  // branch pc_src choice looks at the ALU flags.
  always_comb begin
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    ALUOp        = ALUOP_ADD;
    ALUSrc       = 1'b0;
    BranchType   = 3'b000;
    Jump         = 1'b0;
    lui          = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_PLUS4;
    reg_write    = 1'b0;
    wb_sel       = WB_ALU;
    case (state_reg)
      S_FETCH: mem.imem_req = 1'b1;
      S_EXEC: begin
        case (iclass)
          C_R: ALUOp = ALUOP_R;
          C_I, C_LOAD, C_STORE: ALUSrc = 1'b1;
          C_BRANCH: begin
            ALUOp      = ALUOP_BR;
            BranchType = branch_type(instr_reg[14:12]);
            pc_write   = 1'b1;
            pc_src     = taken ? PC_IMM : PC_PLUS4;
          end
          C_JAL: begin
            Jump     = 1'b1;
            pc_write = 1'b1;
            pc_src   = PC_IMM;
          end
          C_JALR: begin
            Jump     = 1'b1;
            ALUSrc   = 1'b1;
            pc_write = 1'b1;
            pc_src   = PC_ALU;
          end
          C_LUI: lui = 1'b1;
          default: ;
        endcase
      end
      S_MEM: begin
        mem.dmem_req = 1'b1;
        mem.dmem_we  = (iclass == C_STORE);
        pc_write     = (iclass == C_STORE) && mem.dmem_ack;
      end
      S_WB: begin
        reg_write = 1'b1;
        case (iclass)
          C_LOAD: begin
            wb_sel   = WB_MEM;
            pc_write = 1'b1;
          end
          C_JAL, C_JALR: wb_sel = WB_PC4;
          default: pc_write = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule
